// File: rtl/gol_pkg.sv
// Shared constants and types for the 20x20 Game-of-Life engine with VGA output.
package gol_pkg;

  // Default grid side, in cells
  localparam int GRID_N_DEF = 20;

  // 640x480@60 timing, in pixel ticks (horizontal) and lines (vertical)
  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Counter width and counter-width versions of the timing points
  localparam int CW = 10;
  localparam logic [CW-1:0] H_VIS_END  = CW'(H_VIS);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_VIS + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_VIS + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_VIS_END  = CW'(V_VIS);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_VIS + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_VIS + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  // Top-left screen pixel of the grid window
  localparam logic [CW-1:0] GRID_X0 = CW'(160);
  localparam logic [CW-1:0] GRID_Y0 = CW'(80);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_LIVE = 12'hFFF;
  localparam rgb_t RGB_DEAD = 12'h002;
  localparam rgb_t RGB_OFF  = 12'h000;

  // grid[row][col]
  typedef logic [GRID_N_DEF-1:0][GRID_N_DEF-1:0] grid_t;

  // Power-on pattern: a glider in the top-left corner and a horizontal blinker
  function automatic grid_t seed_grid();
    grid_t g;
    g = '0;
    g[0][1]   = 1'b1;
    g[1][2]   = 1'b1;
    g[2][0]   = 1'b1;
    g[2][1]   = 1'b1;
    g[2][2]   = 1'b1;
    g[10][9]  = 1'b1;
    g[10][10] = 1'b1;
    g[10][11] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/game_of_life_20_vga_timing.sv
// 640x480 raster generator: pixel-clock divider, h/v counters, raw sync and
// visible flags (combinational from the counters; the top registers them).
module vga_timing
  import gol_pkg::*;
#(
  parameter int PIX_DIV = 2
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [CW-1:0] o_hcnt,
  output logic [CW-1:0] o_vcnt,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_vis
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [CW-1:0] r_h, r_v;
  logic          w_tick;

  // With PIX_DIV=1 the divider sits at 0 and every clock is a tick
  assign w_tick = (r_div == DW'(PIX_DIV - 1));

  // Pixel-clock divider
  always_ff @(posedge i_clk) begin
    if (i_rst || w_tick) r_div <= '0;
    else                 r_div <= r_div + 1'b1;
  end

  // Raster position; line counter moves when the pixel counter wraps
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
      end else begin
        r_h <= r_h + 1'b1;
      end
    end
  end

  assign o_hcnt  = r_h;
  assign o_vcnt  = r_v;
  assign o_hsync = !((r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END));
  assign o_vsync = !((r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END));
  assign o_vis   = (r_h < H_VIS_END) && (r_v < V_VIS_END);

endmodule

// File: rtl/game_of_life_20.sv
// 20x20 Game-of-Life engine with a 640x480 VGA renderer.
// Optional feature macro GOL_WRAP_EN: toroidal neighbourhood (default: cells
// beyond the edge are dead).
module game_of_life_20
  import gol_pkg::*;
#(
  parameter int GRID_N     = GRID_N_DEF,
  parameter int GEN_PERIOD = 25_000_000,
  parameter int PIX_DIV    = 2,
  parameter int CELL_PX    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam int GW = (GEN_PERIOD > 1) ? $clog2(GEN_PERIOD) : 1;
  localparam int IW = $clog2(GRID_N);
  localparam logic [CW-1:0] WIN_X1 = CW'(int'(GRID_X0) + GRID_N * CELL_PX);
  localparam logic [CW-1:0] WIN_Y1 = CW'(int'(GRID_Y0) + GRID_N * CELL_PX);

`ifdef GOL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [GRID_N-1:0][GRID_N-1:0] r_grid, w_next;
  logic [GRID_N+1:0][GRID_N+1:0] w_pad;
  logic [GW-1:0]                 r_gen;
  logic                          w_step;
  logic [CW-1:0]                 w_hcnt, w_vcnt, w_dx, w_dy;
  logic                          w_hs, w_vs, w_vis, w_in_win, w_live;
  logic [IW-1:0]                 w_row, w_col;
  rgb_t                          w_rgb;

  // Grid framed by a one-cell border: dead, or the opposite edge when wrapping.
  // Border index 0 / GRID_N+1 maps to grid row/col GRID_N-1 / 0.
  for (genvar pr = 0; pr < GRID_N + 2; pr++) begin : g_pr
    for (genvar pc = 0; pc < GRID_N + 2; pc++) begin : g_pc
      localparam int SR = (pr + GRID_N - 1) % GRID_N;
      localparam int SC = (pc + GRID_N - 1) % GRID_N;
      if (WRAP || (pr >= 1 && pr <= GRID_N && pc >= 1 && pc <= GRID_N)) begin : g_src
        assign w_pad[pr][pc] = r_grid[SR][SC];
      end else begin : g_dead
        assign w_pad[pr][pc] = 1'b0;
      end
    end
  end

  // Per-cell neighbour count and birth/survival rule, all cells in parallel
  for (genvar r = 0; r < GRID_N; r++) begin : g_row
    for (genvar c = 0; c < GRID_N; c++) begin : g_col
      logic [3:0] w_cnt;
      assign w_cnt = 4'(w_pad[r][c])   + 4'(w_pad[r][c+1])   + 4'(w_pad[r][c+2])
                   + 4'(w_pad[r+1][c])                       + 4'(w_pad[r+1][c+2])
                   + 4'(w_pad[r+2][c]) + 4'(w_pad[r+2][c+1]) + 4'(w_pad[r+2][c+2]);
      assign w_next[r][c] = (w_cnt == 4'd3) || (r_grid[r][c] && (w_cnt == 4'd2));
    end
  end

  assign w_step = (r_gen == GW'(GEN_PERIOD - 1));

  // Grid state and generation timer; load wins over a coincident step
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grid <= '0;
      r_gen  <= '0;
    end else if (load) begin
      r_grid <= seed_grid();
      r_gen  <= '0;
    end else if (w_step) begin
      r_grid <= w_next;
      r_gen  <= '0;
    end else begin
      r_gen  <= r_gen + 1'b1;
    end
  end

  vga_timing #(.PIX_DIV(PIX_DIV)) u_vga (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_hcnt (w_hcnt),
    .o_vcnt (w_vcnt),
    .o_hsync(w_hs),
    .o_vsync(w_vs),
    .o_vis  (w_vis)
  );

  // Screen position to cell; only meaningful while inside the window
  assign w_in_win = w_vis && (w_hcnt >= GRID_X0) && (w_hcnt < WIN_X1)
                          && (w_vcnt >= GRID_Y0) && (w_vcnt < WIN_Y1);
  assign w_dx     = w_hcnt - GRID_X0;
  assign w_dy     = w_vcnt - GRID_Y0;
  assign w_col    = IW'(w_dx / CW'(CELL_PX));
  assign w_row    = IW'(w_dy / CW'(CELL_PX));
  assign w_live   = w_in_win && r_grid[w_row][w_col];

  // Pixel colour: white live cell, dim blue dead cell, black elsewhere
  always_comb begin
    w_rgb = RGB_OFF;
    if (w_in_win) w_rgb = w_live ? RGB_LIVE : RGB_DEAD;
  end

  // Sync and colour registered together, one clock behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
    end else begin
      hsync_out <= w_hs;
      vsync_out <= w_vs;
      red       <= w_rgb.r;
      green     <= w_rgb.g;
      blue      <= w_rgb.b;
    end
  end

endmodule

// File: tb/tb_game_of_life_20.sv
// Bench for game_of_life_20: two instances (pixel divider 1 and 2) share the
// same reset/load stimulus and are compared every clock against a model that
// plays Life on an array and derives the raster position from elapsed clocks.
module tb_game_of_life_20;
  localparam int GP = 16;
  localparam int N  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b1;
  logic hs_a, vs_a, hs_b, vs_b;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

  always #5 clk = ~clk;

  game_of_life_20 #(.GEN_PERIOD(GP), .PIX_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .hsync_out(hs_a), .vsync_out(vs_a),
    .red(r_a), .green(g_a), .blue(b_a));

  game_of_life_20 #(.GEN_PERIOD(GP), .PIX_DIV(2)) dut_b (
    .clk(clk), .rst(rst), .load(load), .hsync_out(hs_b), .vsync_out(vs_b),
    .red(r_b), .green(g_b), .blue(b_b));

  int errs = 0;
  int checks = 0;
  bit mg[N][N];
  bit mprev[N][N];
  int mk = 0;
  int nv = 0;
  bit started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit gbit(input logic [N-1:0][N-1:0] g, input int r, input int c);
    return g[5'(r)][5'(c)] === 1'b1;
  endfunction

  function automatic int grid_diff(input logic [N-1:0][N-1:0] g);
    int d = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (g[5'(r)][5'(c)] !== mg[r][c]) d++;
    return d;
  endfunction

  // Mismatch count of the DUT grid against an exact 8-cell list (r*100+c)
  function automatic int cells_bad(input logic [N-1:0][N-1:0] g, input int q[8]);
    int bad = 0;
    int pop = 0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (gbit(g, r, c)) pop++;
    for (int i = 0; i < 8; i++)
      if (!gbit(g, q[i] / 100, q[i] % 100)) bad++;
    if (pop != 8) bad++;
    return bad;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mg[r][c] = 1'b0;
  endtask

  task automatic m_seed();
    m_clear();
    mg[0][1] = 1; mg[1][2] = 1; mg[2][0] = 1; mg[2][1] = 1; mg[2][2] = 1;
    mg[10][9] = 1; mg[10][10] = 1; mg[10][11] = 1;
  endtask

  task automatic life_step();
    bit nx[N][N];
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int k;
        k = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int rr, cc;
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
`ifdef GOL_WRAP_EN
            rr = (rr + N) % N;
            cc = (cc + N) % N;
`else
            if (rr < 0 || rr >= N || cc < 0 || cc >= N) continue;
`endif
            k = k + int'(mg[rr][cc]);
          end
        nx[r][c] = mg[r][c] ? (k == 2 || k == 3) : (k == 3);
      end
    mg = nx;
  endtask

  // {hsync, vsync, rgb} expected after n counting clocks at the given divider
  function automatic logic [13:0] vga_exp(input int n, input int pdiv);
    int t, x, y;
    bit hs, vs;
    logic [11:0] rgb;
    t = n / pdiv;
    x = t % 800;
    y = (t / 800) % 525;
    hs = !(x >= 656 && x < 752);
    vs = !(y >= 490 && y < 492);
    rgb = 12'h000;
    if (x < 640 && y < 480 && x >= 160 && x < 480 && y >= 80 && y < 400)
      rgb = mprev[(y - 80) / 16][(x - 160) / 16] ? 12'hFFF : 12'h002;
    return {hs, vs, rgb};
  endfunction

  // Model update at each edge, then compare both DUTs just after it
  always @(posedge clk) begin
    logic [13:0] ea, eb;
    bit rst_edge;
    int x, y;
    rst_edge = rst;
    mprev = mg;
    if (rst) begin
      m_clear();
      mk = 0;
      started = 1'b1;
    end else if (load) begin
      m_seed();
      mk = 0;
    end else begin
      mk++;
      if (mk % GP == 0) life_step();
    end
    if (rst_edge) begin
      ea = 14'h3000;
      eb = 14'h3000;
    end else begin
      ea = vga_exp(nv, 1);
      eb = vga_exp(nv, 2);
    end
    x = nv % 800;
    y = (nv / 800) % 525;
    #1;
    if (started) begin
      chk("grid_a", grid_diff(dut_a.r_grid), 0);
      chk("grid_b", grid_diff(dut_b.r_grid), 0);
      chk("vga_a", 32'({hs_a, vs_a, r_a, g_a, b_a}), 32'(ea));
      chk("vga_b", 32'({hs_b, vs_b, r_b, g_b, b_b}), 32'(eb));
      if (!rst_edge) begin
        if (x == 179 && y == 83) chk("pix_live",  32'({r_a, g_a, b_a}), 32'h0FFF);
        if (x == 165 && y == 85) chk("pix_dead",  32'({r_a, g_a, b_a}), 32'h0002);
        if (x == 10  && y == 10) chk("pix_out",   32'({r_a, g_a, b_a}), 32'h0000);
        if (x == 700 && y == 20) chk("pix_blank", 32'({r_a, g_a, b_a}), 32'h0000);
      end
    end
    if (rst_edge) nv = 0;
    else nv++;
  end

  initial begin
    int q_seed[8], q_g1[8], q_g2[8];
    int ca, cb;
    q_seed = '{1, 102, 200, 201, 202, 1009, 1010, 1011};
    q_g1   = '{100, 102, 201, 202, 301, 910, 1010, 1110};
    q_g2   = '{102, 200, 202, 301, 302, 1009, 1010, 1011};

    // Reset together with load: reset must win
    rst = 1'b1;
    load = 1'b1;
    @(negedge clk);
    chk("rst_hsync", 32'(hs_a), 32'd1);
    chk("rst_vsync", 32'(vs_a), 32'd1);
    chk("rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    chk("rst_grid", 32'(dut_a.r_grid == '0), 32'd1);
    rst = 1'b0;
    load = 1'b0;
    repeat (5) @(negedge clk);

    // Seed, then exactly GEN_PERIOD clocks until the first step
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("seed", cells_bad(dut_a.r_grid, q_seed), 0);
    repeat (GP - 1) @(negedge clk);
    chk("no_step_yet", cells_bad(dut_a.r_grid, q_seed), 0);
    @(negedge clk);
    chk("gen1", cells_bad(dut_a.r_grid, q_g1), 0);
    chk("gen1_b", cells_bad(dut_b.r_grid, q_g1), 0);
    repeat (GP) @(negedge clk);
    chk("gen2", cells_bad(dut_a.r_grid, q_g2), 0);

    // Sync pulse width over one full line of each instance
    ca = 0;
    cb = 0;
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk);
      if (!hs_b) cb++;
      if (i < 800 && !hs_a) ca++;
    end
    chk("hsync_low_div1", ca, 96);
    chk("hsync_low_div2", cb, 192);

    // Hold load so the seed stays on screen while the raster crosses rows 0-1
    while (nv < 60000) @(negedge clk);
    load = 1'b1;
    while (nv < 78000) @(negedge clk);
    load = 1'b0;
    repeat (200) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
